// File: rtl/instr_fetch_if.sv
// Instruction-fetch bus: program-load, control and fetch-result signals
// shared between the CPU controller (master) and instr_fetch (slave).
// Optional macro INSTR_FETCH_BKPT_EN adds the breakpoint inputs.
interface instr_fetch_if;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic       start;
  logic       fetch_req;
  logic       pc_load;
  logic [3:0] pc_target;
  logic       halt_req;
`ifdef INSTR_FETCH_BKPT_EN
  logic       bkpt_en;
  logic [3:0] bkpt_addr;
`endif
  logic [7:0] instruction;
  logic       instr_valid;
  logic [3:0] pc;
  logic [1:0] state;

`ifdef INSTR_FETCH_BKPT_EN
  modport master (
    output prog_we, prog_addr, prog_data, start, fetch_req, pc_load,
           pc_target, halt_req, bkpt_en, bkpt_addr,
    input  instruction, instr_valid, pc, state
  );
  modport slave (
    input  prog_we, prog_addr, prog_data, start, fetch_req, pc_load,
           pc_target, halt_req, bkpt_en, bkpt_addr,
    output instruction, instr_valid, pc, state
  );
`else
  modport master (
    output prog_we, prog_addr, prog_data, start, fetch_req, pc_load,
           pc_target, halt_req,
    input  instruction, instr_valid, pc, state
  );
  modport slave (
    input  prog_we, prog_addr, prog_data, start, fetch_req, pc_load,
           pc_target, halt_req,
    output instruction, instr_valid, pc, state
  );
`endif
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: 16x8 program memory, 4-bit PC and an
// IDLE/RUN/HALT sequencer delivering one byte per fetch request.
// Optional macro INSTR_FETCH_BKPT_EN adds a single-address breakpoint
// that halts before the matching fetch.
module instr_fetch #(
  parameter logic [3:0] RESET_PC    = 4'h0,
  parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
  input logic         clk,
  input logic         reset,
  instr_fetch_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [7:0] instr_q, instr_d;
  logic       valid_q, valid_d;
  logic [7:0] mem_q [16];

  logic [3:0] fetch_addr;
  logic [7:0] fetch_byte;
  logic       bkpt_hit;

  // A jump issued with a fetch redirects that very fetch.
  assign fetch_addr = bus.pc_load ? bus.pc_target : pc_q;
  assign fetch_byte = mem_q[fetch_addr];

`ifdef INSTR_FETCH_BKPT_EN
  assign bkpt_hit = bus.bkpt_en && (fetch_addr == bus.bkpt_addr);
`else
  assign bkpt_hit = 1'b0;
`endif

  // Program memory write port, open only while IDLE and not in reset.
  // NOTE: the memory array has no reset branch; program contents survive
  // reset, and leaving it out keeps the array mappable onto RAM/LUT storage.
  always_ff @(posedge clk) begin
    if (!reset && state_q == IDLE && bus.prog_we) begin
      mem_q[bus.prog_addr] <= bus.prog_data;
    end
  end

  // Next-state logic for the sequencer, PC and fetch outputs.
  // NOTE: every _d signal gets a default before the case so that no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) state_d = RUN;
      end
      RUN: begin
        if (bus.halt_req) begin
          state_d = HALT;
        end else if (bus.fetch_req) begin
          if (bkpt_hit) begin
            state_d = HALT;
          end else begin
            instr_d = fetch_byte;
            valid_d = 1'b1;
            pc_d    = fetch_addr + 4'd1;
            if (fetch_byte == HALT_OPCODE) state_d = HALT;
          end
        end else if (bus.pc_load) begin
          pc_d = bus.pc_target;
        end
      end
      HALT: begin
        if (bus.start) begin
          state_d = RUN;
          pc_d    = RESET_PC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset taking priority over all inputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign bus.instruction = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.pc          = pc_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch.
// Define INSTR_FETCH_BKPT_EN to include the breakpoint scenario.
module tb_instr_fetch;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_HALT = 2'b10;

  instr_fetch_if bus_if ();

  instr_fetch #(.RESET_PC(4'h0), .HALT_OPCODE(8'hFF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // Inputs change 1 ns after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus_if.prog_we   = 1'b0;
    bus_if.prog_addr = 4'h0;
    bus_if.prog_data = 8'h00;
    bus_if.start     = 1'b0;
    bus_if.fetch_req = 1'b0;
    bus_if.pc_load   = 1'b0;
    bus_if.pc_target = 4'h0;
    bus_if.halt_req  = 1'b0;
`ifdef INSTR_FETCH_BKPT_EN
    bus_if.bkpt_en   = 1'b0;
    bus_if.bkpt_addr = 4'h0;
`endif
  endtask

  task automatic write_mem(input logic [3:0] a, input logic [7:0] d);
    bus_if.prog_we   = 1'b1;
    bus_if.prog_addr = a;
    bus_if.prog_data = d;
    tick();
    bus_if.prog_we   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic do_start();
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
  endtask

  // One cycle of fetch_req with optional jump; checks byte, strobe and pc.
  task automatic fetch(input string tag, input logic load, input logic [3:0] tgt,
                       input logic [7:0] exp_i, input logic [3:0] exp_pc);
    bus_if.fetch_req = 1'b1;
    bus_if.pc_load   = load;
    bus_if.pc_target = tgt;
    tick();
    bus_if.fetch_req = 1'b0;
    bus_if.pc_load   = 1'b0;
    check({tag, "_instr"}, bus_if.instruction, exp_i);
    check({tag, "_valid"}, bus_if.instr_valid, 1'b1);
    check({tag, "_pc"},    bus_if.pc,          exp_pc);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst_state", bus_if.state,       S_IDLE);
    check("rst_pc",    bus_if.pc,          4'h0);
    check("rst_instr", bus_if.instruction, 8'h00);
    check("rst_valid", bus_if.instr_valid, 1'b0);

    // Program load; fetch_req/pc_load in IDLE must be ignored.
    write_mem(4'd0, 8'h11);
    write_mem(4'd1, 8'h22);
    write_mem(4'd2, 8'h33);
    write_mem(4'd4, 8'hFF);
    write_mem(4'd5, 8'h55);
    write_mem(4'd9, 8'h99);
    write_mem(4'd15, 8'h5A);
    bus_if.fetch_req = 1'b1;
    bus_if.pc_load   = 1'b1;
    bus_if.pc_target = 4'd7;
    tick();
    idle_inputs();
    check("idle_ign_state", bus_if.state,       S_IDLE);
    check("idle_ign_pc",    bus_if.pc,          4'h0);
    check("idle_ign_valid", bus_if.instr_valid, 1'b0);

    do_start();
    check("start_state", bus_if.state, S_RUN);
    check("start_pc",    bus_if.pc,    4'h0);

    // Three back-to-back fetches.
    fetch("seq0", 1'b0, 4'h0, 8'h11, 4'd1);
    fetch("seq1", 1'b0, 4'h0, 8'h22, 4'd2);
    fetch("seq2", 1'b0, 4'h0, 8'h33, 4'd3);
    tick();
    check("hold_valid", bus_if.instr_valid, 1'b0);
    check("hold_instr", bus_if.instruction, 8'h33);
    check("hold_pc",    bus_if.pc,          4'd3);

    // prog_we and start in RUN have no effect.
    bus_if.prog_we   = 1'b1;
    bus_if.prog_addr = 4'd5;
    bus_if.prog_data = 8'h77;
    bus_if.start     = 1'b1;
    tick();
    idle_inputs();
    check("run_we_state", bus_if.state, S_RUN);
    check("run_we_pc",    bus_if.pc,    4'd3);
    fetch("jf5", 1'b1, 4'd5, 8'h55, 4'd6);

    // Jump alone, then jump+fetch from pc=2.
    bus_if.pc_load   = 1'b1;
    bus_if.pc_target = 4'd2;
    tick();
    idle_inputs();
    check("jmp2_pc",    bus_if.pc,          4'd2);
    check("jmp2_valid", bus_if.instr_valid, 1'b0);
    check("jmp2_instr", bus_if.instruction, 8'h55);
    fetch("jf9", 1'b1, 4'd9, 8'h99, 4'd10);
    bus_if.pc_load   = 1'b1;
    bus_if.pc_target = 4'd9;
    tick();
    idle_inputs();
    check("jmp9_pc",    bus_if.pc,          4'd9);
    check("jmp9_valid", bus_if.instr_valid, 1'b0);

    // halt_req outranks fetch_req and pc_load.
    bus_if.halt_req  = 1'b1;
    bus_if.fetch_req = 1'b1;
    bus_if.pc_load   = 1'b1;
    bus_if.pc_target = 4'd0;
    tick();
    check("hreq_state", bus_if.state,       S_HALT);
    check("hreq_pc",    bus_if.pc,          4'd9);
    check("hreq_valid", bus_if.instr_valid, 1'b0);
    check("hreq_instr", bus_if.instruction, 8'h99);
    tick();
    idle_inputs();
    check("halt_ign_state", bus_if.state,       S_HALT);
    check("halt_ign_pc",    bus_if.pc,          4'd9);
    check("halt_ign_valid", bus_if.instr_valid, 1'b0);
    do_start();
    check("restart_state", bus_if.state, S_RUN);
    check("restart_pc",    bus_if.pc,    4'd0);

    // HALT opcode delivered, then halts.
    fetch("ff", 1'b1, 4'd4, 8'hFF, 4'd5);
    check("ff_state", bus_if.state, S_HALT);
    bus_if.fetch_req = 1'b1;
    tick();
    idle_inputs();
    check("ff_nofetch_valid", bus_if.instr_valid, 1'b0);
    check("ff_nofetch_instr", bus_if.instruction, 8'hFF);
    check("ff_nofetch_pc",    bus_if.pc,          4'd5);
    do_start();
    check("ff_restart_state", bus_if.state, S_RUN);
    check("ff_restart_pc",    bus_if.pc,    4'd0);

    // Reset mid-fetch and mid-write.
    fetch("pre_rst", 1'b0, 4'h0, 8'h11, 4'd1);
    bus_if.fetch_req = 1'b1;
    bus_if.prog_we   = 1'b1;
    bus_if.prog_addr = 4'd1;
    bus_if.prog_data = 8'hEE;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle_inputs();
    check("mrst_state", bus_if.state,       S_IDLE);
    check("mrst_pc",    bus_if.pc,          4'd0);
    check("mrst_instr", bus_if.instruction, 8'h00);
    check("mrst_valid", bus_if.instr_valid, 1'b0);

    // PC wrap: memory contents survived reset.
    write_mem(4'd0, 8'h6B);
    do_start();
    fetch("mem1", 1'b1, 4'd1, 8'h22, 4'd2);
    bus_if.pc_load   = 1'b1;
    bus_if.pc_target = 4'd15;
    tick();
    idle_inputs();
    check("wrap_pre_pc", bus_if.pc, 4'd15);
    fetch("wrap15", 1'b0, 4'h0, 8'h5A, 4'd0);
    fetch("wrap0",  1'b0, 4'h0, 8'h6B, 4'd1);

`ifdef INSTR_FETCH_BKPT_EN
    do_reset();
    write_mem(4'd0, 8'h11);
    do_start();
    bus_if.bkpt_en   = 1'b1;
    bus_if.bkpt_addr = 4'd3;
    fetch("bk0", 1'b0, 4'h0, 8'h11, 4'd1);
    fetch("bk1", 1'b0, 4'h0, 8'h22, 4'd2);
    fetch("bk2", 1'b0, 4'h0, 8'h33, 4'd3);
    bus_if.fetch_req = 1'b1;
    tick();
    check("bk_state", bus_if.state,       S_HALT);
    check("bk_pc",    bus_if.pc,          4'd3);
    check("bk_valid", bus_if.instr_valid, 1'b0);
    idle_inputs();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
